// File: rtl/xnor_gate_primitive.sv
// -----------------------------------------------------------------------------
// xnor_gate_primitive
//
// Parameterised bitwise XNOR / equality unit. It provides two views of the
// XNOR of two operands:
//   * a zero-latency combinational result (the drop-in equivalent of a
//     2-input XNOR primitive), and
//   * a registered result with valid tagging, an all-bits-equal flag and a
//     saturating count of mismatching operand pairs.
//
// Parameters
//   WIDTH      operand / result width in bits (>= 1)
//   CNT_WIDTH  width of the saturating mismatch counter (>= 1)
//
// Ports
//   clk           in   1          rising-edge clock
//   rst_n         in   1          asynchronous active-low reset
//   in1           in   WIDTH      operand A
//   in2           in   WIDTH      operand B
//   in_valid      in   1          operand pair is valid this cycle
//   cnt_clr       in   1          synchronous clear of mismatch_cnt
//   out_comb      out  WIDTH      combinational ~(in1 ^ in2)
//   out           out  WIDTH      registered XNOR result
//   out_valid     out  1          out / eq valid (one cycle per accepted pair)
//   eq            out  1          registered all-bits-equal flag
//   mismatch_cnt  out  CNT_WIDTH  accepted pairs with eq == 0, saturating
//
// Handshake: a pair is accepted on every rising clk edge where in_valid is
// high. There is no ready signal; the unit accepts one pair per cycle with no
// backpressure, and out_valid follows in_valid with exactly one cycle of
// latency. When in_valid is low, out and eq keep their last value while
// out_valid drops.
// -----------------------------------------------------------------------------
module xnor_gate_primitive #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic                 in_valid,
    input  logic                 cnt_clr,
    output logic [WIDTH-1:0]     out_comb,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic                 eq,
    output logic [CNT_WIDTH-1:0] mismatch_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [WIDTH-1:0] xnor_val;
    logic             eq_next;
    logic             cnt_inc;

    // The combinational path is independent of clk and rst_n; X/Z on the
    // operands propagates exactly as the Verilog operators define.
    assign xnor_val = ~(in1 ^ in2);
    assign out_comb = xnor_val;

    // All bits equal means every XNOR bit is set.
    assign eq_next  = &xnor_val;

    // Count only accepted pairs that mismatch, and stop at all-ones.
    assign cnt_inc  = in_valid && !eq_next && (mismatch_cnt != CNT_MAX);

    // Result registers: out/eq load only on accepted pairs, out_valid tracks
    // in_valid with one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            eq        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= xnor_val;
                eq  <= eq_next;
            end
        end
    end

    // Mismatch counter: a clear wins over an increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt <= '0;
        end else if (cnt_clr) begin
            mismatch_cnt <= '0;
        end else if (cnt_inc) begin
            mismatch_cnt <= mismatch_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_xnor_gate_primitive.sv
// -----------------------------------------------------------------------------
// tb_xnor_gate_primitive
//
// Two instances: a 4-bit unit with a 2-bit counter (registered path,
// saturation, reset behaviour) and a 1-bit unit with the default counter
// (primitive-equivalent combinational path and single-bit registered path).
// -----------------------------------------------------------------------------
module tb_xnor_gate_primitive;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 4-bit instance ----------------
    logic [3:0] in1_4 = '0, in2_4 = '0;
    logic       in_valid_4 = 1'b0, cnt_clr_4 = 1'b0;
    logic [3:0] out_comb_4, out_4;
    logic       out_valid_4, eq_4;
    logic [1:0] cnt_4;

    xnor_gate_primitive #(.WIDTH(4), .CNT_WIDTH(2)) dut_w4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in1          (in1_4),
        .in2          (in2_4),
        .in_valid     (in_valid_4),
        .cnt_clr      (cnt_clr_4),
        .out_comb     (out_comb_4),
        .out          (out_4),
        .out_valid    (out_valid_4),
        .eq           (eq_4),
        .mismatch_cnt (cnt_4)
    );

    // ---------------- 1-bit instance ----------------
    logic       in1_1 = 1'b0, in2_1 = 1'b0;
    logic       in_valid_1 = 1'b0, cnt_clr_1 = 1'b0;
    logic       out_comb_1, out_1, out_valid_1, eq_1;
    logic [7:0] cnt_1;

    xnor_gate_primitive #(.WIDTH(1), .CNT_WIDTH(8)) dut_w1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in1          (in1_1),
        .in2          (in2_1),
        .in_valid     (in_valid_1),
        .cnt_clr      (cnt_clr_1),
        .out_comb     (out_comb_1),
        .out          (out_1),
        .out_valid    (out_valid_1),
        .eq           (eq_1),
        .mismatch_cnt (cnt_1)
    );

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    // Scoreboard entry: {mismatch_cnt[1:0], eq, out[3:0]}
    logic [6:0] exp_q[$];
    logic [1:0] m_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver for the 4-bit instance: inputs change on the falling edge and
    // are captured on the next rising edge. The expected result is pushed at
    // drive time and popped by the monitor when out_valid appears.
    task automatic drive(input logic [3:0] a, input logic [3:0] b,
                         input logic v, input logic clr);
        logic [3:0] x;
        @(negedge clk);
        in1_4      = a;
        in2_4      = b;
        in_valid_4 = v;
        cnt_clr_4  = clr;
        x = ~(a ^ b);
        if (clr)
            m_cnt = 2'd0;
        else if (v && (x != 4'hF) && (m_cnt != 2'd3))
            m_cnt = m_cnt + 2'd1;
        if (v)
            exp_q.push_back({m_cnt, (x == 4'hF), x});
    endtask

    // Monitor: samples 2 time units after each rising edge.
    always @(posedge clk) begin
        logic [6:0] e;
        #2;
        if (out_valid_4) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected_valid: got out=%0h with no expected entry at %0t", out_4, $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_out", 32'(out_4), 32'(e[3:0]));
                check("sb_eq",  32'(eq_4),  32'(e[4]));
                check("sb_cnt", 32'(cnt_4), 32'(e[6:5]));
            end
        end
    end

    // ---------------- vector tables ----------------
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_out;
        logic       exp_eq;
    } vec_t;

    typedef struct packed {
        logic a;
        logic b;
        logic exp_out;
    } vec1_t;

    vec_t  vecs[8];
    vec1_t vecs1[4];

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b1010, 4'b1001, 4'b1100, 1'b0};
        vecs[1] = '{4'b1111, 4'b1111, 4'b1111, 1'b1};
        vecs[2] = '{4'b0000, 4'b0000, 4'b1111, 1'b1};
        vecs[3] = '{4'b0101, 4'b1010, 4'b0000, 1'b0};
        vecs[4] = '{4'b0011, 4'b0110, 4'b1010, 1'b0};
        vecs[5] = '{4'b1000, 4'b1000, 4'b1111, 1'b1};
        vecs[6] = '{4'b1110, 4'b0111, 4'b0110, 1'b0};
        vecs[7] = '{4'b0001, 4'b0000, 4'b1110, 1'b0};

        vecs1[0] = '{1'b0, 1'b0, 1'b1};
        vecs1[1] = '{1'b0, 1'b1, 1'b0};
        vecs1[2] = '{1'b1, 1'b0, 1'b0};
        vecs1[3] = '{1'b1, 1'b1, 1'b1};

        // ---- reset state, combinational path alive during reset ----
        #1;
        check("rst_comb_w4", 32'(out_comb_4), 32'hF);
        check("rst_comb_w1", 32'(out_comb_1), 32'h1);
        check("rst_out",     32'(out_4), 32'h0);
        check("rst_valid",   32'(out_valid_4), 32'h0);
        check("rst_eq",      32'(eq_4), 32'h0);
        check("rst_cnt",     32'(cnt_4), 32'h0);

        // Valid operands while reset is held must not be captured.
        in1_4 = 4'hF; in2_4 = 4'hF; in_valid_4 = 1'b1;
        @(posedge clk); #2;
        check("rst_hold_out",   32'(out_4), 32'h0);
        check("rst_hold_valid", 32'(out_valid_4), 32'h0);
        check("rst_hold_eq",    32'(eq_4), 32'h0);

        // ---- 1-bit combinational truth table, clock-independent timing ----
        in1_1 = 1'b0; in2_1 = 1'b0;
        #1 check("comb_w1_00", 32'(out_comb_1), 32'h1);
        in2_1 = 1'b1;
        #1 check("comb_w1_01_step", 32'(out_comb_1), 32'h0);
        for (int i = 0; i < 4; i++) begin
            #5;
            in1_1 = vecs1[i].a;
            in2_1 = vecs1[i].b;
            #1 check($sformatf("comb_w1_tt%0d", i), 32'(out_comb_1), 32'(vecs1[i].exp_out));
        end

        // ---- release reset away from a clock edge ----
        @(negedge clk);
        in_valid_4 = 1'b0;
        in1_4 = '0; in2_4 = '0;
        in1_1 = 1'b0; in2_1 = 1'b0;
        #2 rst_n = 1'b1;

        // ---- 1-bit registered path: capture, then hold ----
        @(negedge clk);
        in1_1 = 1'b1; in2_1 = 1'b1; in_valid_1 = 1'b1;
        @(posedge clk); #2;
        check("w1_out",   32'(out_1), 32'h1);
        check("w1_eq",    32'(eq_1), 32'h1);
        check("w1_valid", 32'(out_valid_1), 32'h1);
        @(negedge clk);
        in1_1 = 1'b0; in_valid_1 = 1'b0;
        @(posedge clk); #2;
        check("w1_hold_valid", 32'(out_valid_1), 32'h0);
        check("w1_hold_out",   32'(out_1), 32'h1);
        check("w1_hold_cnt",   32'(cnt_1), 32'h0);

        // ---- 4-bit table, back-to-back, with zero-latency comb check ----
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].a, vecs[i].b, 1'b1, 1'b0);
            #1 check($sformatf("tbl_comb%0d", i), 32'(out_comb_4), 32'(vecs[i].exp_out));
            tests++;
            if (vecs[i].exp_eq !== (vecs[i].exp_out == 4'hF)) begin
                fails++;
                $display("FAIL tbl_entry%0d: eq %0b out %0h inconsistent", i, vecs[i].exp_eq, vecs[i].exp_out);
            end
        end

        // ---- hold when in_valid drops ----
        drive(4'b0110, 4'b0110, 1'b1, 1'b0);
        drive(4'b0001, 4'b1000, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("hold_valid", 32'(out_valid_4), 32'h0);
        check("hold_out",   32'(out_4), 32'hF);
        check("hold_eq",    32'(eq_4), 32'h1);

        // ---- saturation with a 2-bit counter, then clear beats increment ----
        drive(4'h0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            drive(4'hA, 4'h5, 1'b1, 1'b0);
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("sat_cnt", 32'(cnt_4), 32'h3);
        drive(4'h3, 4'h0, 1'b1, 1'b1);
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("clr_prio_cnt", 32'(cnt_4), 32'h0);

        // ---- random stimulus ----
        for (int i = 0; i < 24; i++) begin
            logic [3:0] a, b;
            a = 4'($urandom_range(0, 15));
            b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
            drive(a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        drive(4'h0, 4'h0, 1'b0, 1'b1);
        drive(4'h0, 4'h0, 1'b0, 1'b0);

        // ---- asynchronous reset mid-stream ----
        drive(4'hC, 4'h4, 1'b1, 1'b0);
        drive(4'h9, 4'h9, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out",   32'(out_4), 32'h0);
        check("arst_valid", 32'(out_valid_4), 32'h0);
        check("arst_eq",    32'(eq_4), 32'h0);
        check("arst_cnt",   32'(cnt_4), 32'h0);
        check("arst_comb",  32'(out_comb_4), 32'hF);
        exp_q.delete();
        m_cnt = 2'd0;
        @(posedge clk); #2;
        check("arst_held_valid", 32'(out_valid_4), 32'h0);
        check("arst_held_out",   32'(out_4), 32'h0);

        // First capture after release is the first edge with in_valid high.
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        drive(4'h9, 4'h6, 1'b1, 1'b0);
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        @(posedge clk); #3;

        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
